rv32m_div_unit: RTL and testbench

- Multi-cycle iterative divider that executes the RV32M DIV, DIVU, REM and REMU instructions.
- The single-cycle ALU does not implement these opcodes.
- Sits beside the ALU in the execute stage. The pipeline control stalls on busy and captures result on done.
- Uses a radix-2 restoring algorithm: one quotient bit per cycle, fixed latency, with RISC-V special cases short-circuited.

---
 rtl/rv32m_div_pkg.sv | 29 ++
 rtl/rv32m_div_unit_divu_step.sv | 31 +++
 rtl/rv32m_div_unit.sv | 167 ++++++++++++++++
 tb/tb_rv32m_div_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_div_pkg.sv
// ---------------------------------------------------------------------------
// rv32m_div_pkg
// Shared definitions for the RV32M iterative divider: default operand width,
// operation encodings, FSM state encoding and the constants used by the
// RISC-V divide special cases.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32m_div_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Operation encodings as presented on the op input.
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Most negative signed value and the all-ones pattern at the default width.
  localparam logic [XLEN_DEFAULT-1:0] INT_MIN  = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};
  localparam logic [XLEN_DEFAULT-1:0] ALL_ONES = {XLEN_DEFAULT{1'b1}};

endpackage

// File: rtl/rv32m_div_unit_divu_step.sv
// ---------------------------------------------------------------------------
// divu_step
// One iteration of unsigned radix-2 restoring division (combinational).
// Ports:
//   rem      in  XLEN  partial remainder before this step
//   dvd_msb  in  1     next dividend bit to bring down
//   dsr      in  XLEN  divisor (unsigned magnitude)
//   next_rem out XLEN  partial remainder after this step
//   q_bit    out 1     quotient bit produced by this step
// ---------------------------------------------------------------------------
module divu_step
  import rv32m_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] dsr,
  output logic [XLEN-1:0] next_rem,
  output logic            q_bit
);

  logic [XLEN-1:0] shifted;

  // The partial remainder is always below 2^k after k steps, so dropping its
  // top bit on the shift never loses information within XLEN iterations.
  assign shifted  = {rem[XLEN-2:0], dvd_msb};
  assign q_bit    = (shifted >= dsr);
  assign next_rem = q_bit ? (shifted - dsr) : shifted;

endmodule

// File: rtl/rv32m_div_unit.sv
// ---------------------------------------------------------------------------
// rv32m_div_unit
// Multi-cycle iterative divider for RV32M DIV, DIVU, REM and REMU.
// Normal operations take XLEN CALC cycles plus one DONE cycle; divide by zero
// and signed overflow are resolved at start and go straight to DONE.
// Ports:
//   clk     in  1     rising-edge clock
//   rst     in  1     synchronous active-high reset
//   start   in  1     request, accepted only in IDLE without kill
//   op      in  2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   A       in  XLEN  dividend
//   B       in  XLEN  divisor
//   kill    in  1     abort any operation in flight
//   busy    out 1     high in CALC and DONE
//   done    out 1     one-cycle pulse, result valid
//   result  out XLEN  quotient or remainder, held between operations
// ---------------------------------------------------------------------------
module rv32m_div_unit
  import rv32m_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_COUNT = CW'(XLEN - 1);

  // Width-matched special-case constants; the package values apply directly
  // at the default width.
  localparam logic [XLEN-1:0] MIN_NEG =
    (XLEN == XLEN_DEFAULT) ? INT_MIN : {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES =
    (XLEN == XLEN_DEFAULT) ? ALL_ONES : {XLEN{1'b1}};

  div_state_t      state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dsr;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic            sign_q;
  logic            sign_r;
  logic            want_rem;

  logic            is_signed;
  logic            is_rem_op;
  logic            div_by_zero;
  logic            overflow;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic [XLEN-1:0] final_q;

  // Decode of the request presented with start. Magnitudes of signed operands
  // are taken here so the iteration only ever sees unsigned values; the
  // magnitude of INT_MIN wraps to itself, which is correct when read unsigned.
  assign is_signed   = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  assign is_rem_op   = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  assign div_by_zero = (B == '0);
  assign overflow    = is_signed && (A == MIN_NEG) && (B == ONES);
  assign abs_a       = (is_signed && A[XLEN-1]) ? -A : A;
  assign abs_b       = (is_signed && B[XLEN-1]) ? -B : B;

  divu_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem     (rem),
    .dvd_msb (dvd[XLEN-1]),
    .dsr     (dsr),
    .next_rem(step_rem),
    .q_bit   (step_q)
  );

  // Quotient including the bit produced this cycle, so the last iteration
  // can be finalised on the same edge it completes.
  assign final_q = {quo[XLEN-2:0], step_q};

  // Control FSM together with the datapath registers. kill drops back to IDLE
  // without touching result; rst clears everything and has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      quo      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      want_rem <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !kill) begin
            busy <= 1'b1;
            if (div_by_zero) begin
              result <= is_rem_op ? A : ONES;
              done   <= 1'b1;
              state  <= DONE;
            end else if (overflow) begin
              result <= is_rem_op ? '0 : MIN_NEG;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              dvd      <= abs_a;
              dsr      <= abs_b;
              rem      <= '0;
              quo      <= '0;
              count    <= '0;
              sign_q   <= is_signed && (A[XLEN-1] ^ B[XLEN-1]);
              sign_r   <= is_signed && A[XLEN-1];
              want_rem <= is_rem_op;
              state    <= CALC;
            end
          end
        end

        CALC: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem   <= step_rem;
            quo   <= final_q;
            dvd   <= {dvd[XLEN-2:0], 1'b0};
            count <= count + 1'b1;
            if (count == LAST_COUNT) begin
              if (want_rem) begin
                result <= sign_r ? -step_rem : step_rem;
              end else begin
                result <= sign_q ? -final_q : final_q;
              end
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// ---------------------------------------------------------------------------
// tb_rv32m_div_unit
// Self-checking bench for rv32m_div_unit. A reference model built from plain
// 64-bit arithmetic predicts busy/done/result every cycle; directed vectors
// carry hand-computed results and latencies.
// ---------------------------------------------------------------------------
module tb_rv32m_div_unit;
  import rv32m_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  opSel = DIV_OP_DIV;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checkCount = 0;
  int errorCount = 0;
  bit chkEn = 1'b0;

  // Reference model state.
  logic        mBusy = 1'b0;
  logic        mDone = 1'b0;
  logic [31:0] mResult = '0;
  logic [31:0] mPending = '0;
  int          mRemaining = 0;

  rv32m_div_unit #(
    .XLEN(32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (opSel),
    .A     (dividend),
    .B     (divisor),
    .kill  (kill),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // RISC-V divide semantics from 64-bit arithmetic: widening removes the
  // signed overflow case, and truncating back gives the architected value.
  function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (b == 32'd0) begin
      return (o == DIV_OP_REM || o == DIV_OP_REMU) ? a : 32'hFFFF_FFFF;
    end
    case (o)
      DIV_OP_DIV:  return 32'(sa / sb);
      DIV_OP_DIVU: return 32'(ua / ub);
      DIV_OP_REM:  return 32'(sa % sb);
      default:     return 32'(ua % ub);
    endcase
  endfunction

  // Cycles from the start cycle to the done cycle.
  function automatic int refLatency(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    bit isSigned;
    isSigned = (o == DIV_OP_DIV || o == DIV_OP_REM);
    if (b == 32'd0) return 1;
    if (isSigned && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Transaction-level model: an accepted request completes after its latency,
  // kill drops it, reset clears everything.
  always @(posedge clk) begin
    if (rst) begin
      mBusy      <= 1'b0;
      mDone      <= 1'b0;
      mRemaining <= 0;
      mResult    <= '0;
    end else if (mBusy && kill) begin
      mBusy      <= 1'b0;
      mDone      <= 1'b0;
      mRemaining <= 0;
    end else if (mBusy) begin
      if (mDone) begin
        mBusy <= 1'b0;
        mDone <= 1'b0;
      end else begin
        mRemaining <= mRemaining - 1;
        if (mRemaining == 1) begin
          mDone   <= 1'b1;
          mResult <= mPending;
        end
      end
    end else if (start && !kill) begin
      mBusy      <= 1'b1;
      mPending   <= refResult(opSel, dividend, divisor);
      mRemaining <= refLatency(opSel, dividend, divisor) - 1;
      if (refLatency(opSel, dividend, divisor) == 1) begin
        mDone   <= 1'b1;
        mResult <= refResult(opSel, dividend, divisor);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("cycle busy", {31'd0, busy}, {31'd0, mBusy});
      checkOutput("cycle done", {31'd0, done}, {31'd0, mDone});
      checkOutput("cycle result", result, mResult);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one cycle (cycle 0), then scramble the
  // operands to show only the captured copies matter.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    opSel    = o;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    opSel    = 2'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Called at cycle firstCyc; waits (bounded) for done and checks latency,
  // result and the return to idle on the following cycle.
  task automatic waitDone(input string name, input int firstCyc, input logic [31:0] expRes,
                          input int expLat);
    int cyc;
    bit seen;
    cyc  = firstCyc;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    checkOutput({name, " latency"}, seen ? 32'(cyc) : 32'd0, 32'(expLat));
    checkOutput({name, " result"}, result, expRes);
    tick();
    checkOutput({name, " idle after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    applyStimulus(o, a, b);
    waitDone(name, 1, expRes, expLat);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneSeen;

    // Model pinned against hand-computed values.
    checkOutput("model DIV 100/7", refResult(DIV_OP_DIV, 32'd100, 32'd7), 32'd14);
    checkOutput("model REM -7/2", refResult(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    checkOutput("model DIVU ~0/2", refResult(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd2), 32'h7FFF_FFFF);
    checkOutput("model DIV ovf", refResult(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    checkOutput("model REMU by 0", refResult(DIV_OP_REMU, 32'd5, 32'd0), 32'd5);
    checkOutput("model lat ovf", 32'(refLatency(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF)), 32'd1);

    // Reset.
    tick();
    chkEn = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    tick();

    // Normal and signed arithmetic.
    runOp("DIV 100/7", DIV_OP_DIV, 32'd100, 32'd7, 32'd14, 33);
    runOp("REM 100/7", DIV_OP_REM, 32'd100, 32'd7, 32'd2, 33);
    runOp("DIV -7/2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    runOp("REM -7/2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    runOp("REM 7/-2", DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    runOp("DIVU ~0/2", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33);
    runOp("REMU ~0/2", DIV_OP_REMU, 32'hFFFF_FFFF, 32'd2, 32'd1, 33);
    runOp("DIV -1/2", DIV_OP_DIV, 32'hFFFF_FFFF, 32'd2, 32'd0, 33);
    runOp("REMU big", DIV_OP_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    runOp("DIVU big", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);

    // Special cases.
    runOp("DIV by 0", DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("REMU by 0", DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    runOp("DIV ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("REM ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    runOp("DIVU ovf ops", DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // kill together with start in IDLE: not accepted.
    start = 1'b1; kill = 1'b1; opSel = DIV_OP_DIV; dividend = 32'd50; divisor = 32'd5;
    tick();
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    checkOutput("kill+start busy", {31'd0, busy}, 32'd0);
    tick();

    // start pulsed during cycle 10 is ignored.
    applyStimulus(DIV_OP_DIV, 32'd1000, 32'd7);
    repeat (9) tick();
    start = 1'b1; opSel = DIV_OP_REM; dividend = 32'd5; divisor = 32'd0;
    tick();
    start = 1'b0;
    waitDone("DIV 1000/7 start ignored", 11, 32'd142, 33);

    // kill at cycle 15: idle at cycle 16, no done, result kept.
    applyStimulus(DIV_OP_DIV, 32'd1000, 32'd10);
    repeat (14) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    @(negedge clk);
    checkOutput("kill busy", {31'd0, busy}, 32'd0);
    checkOutput("kill result kept", result, 32'd142);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("kill no done", 32'(doneSeen), 32'd0);
    tick();

    // rst at cycle 20: everything zero next cycle.
    applyStimulus(DIV_OP_DIV, 32'd1000, 32'd10);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst done", {31'd0, done}, 32'd0);
    checkOutput("rst result", result, 32'd0);
    tick();

    // DIV 9/3 afterwards; a start held in its DONE cycle must be ignored.
    applyStimulus(DIV_OP_DIV, 32'd9, 32'd3);
    repeat (32) tick();
    start = 1'b1; opSel = DIV_OP_DIV; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    checkOutput("DIV 9/3 done c33", {31'd0, done}, 32'd1);
    checkOutput("DIV 9/3 result", result, 32'd3);
    tick();
    start = 1'b0;
    @(negedge clk);
    checkOutput("start in DONE ignored", {31'd0, busy}, 32'd0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
